ex_operand_forward: RTL and testbench
=====================================

Name: ex_operand_forward

Overview:
- EX-stage operand selector that directly consumes the stall and four forwarding flags from the hazard detection stage.
- Owns the EX/MEM and MEM/WB result-holding registers.
- Drives the final ALU operands, choosing between register-file data, the previous instruction's result (EX-EX) and the result from two instructions back (MEM-EX).
- Inserts a bubble into EX/MEM on load-use stalls and keeps saturating performance counters for stalls and forwards.

Parameters:
XLEN, 32, datapath width
CNT_W, 16, width of performance counters

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  load-use stall from hazard detection; EX instruction must not advance
forwarding_EX_EX1  in  1  rs1 takes result of instruction one ahead
forwarding_EX_EX2  in  1  rs2 takes result of instruction one ahead
forwarding_MEM_EX1  in  1  rs1 takes result of instruction two ahead
forwarding_MEM_EX2  in  1  rs2 takes result of instruction two ahead
rs1_data  in  XLEN  register-file read data, rs1
rs2_data  in  XLEN  register-file read data, rs2
ex_result  in  XLEN  ALU result of instruction currently in EX
ex_valid  in  1  EX holds a real, result-writing instruction
mem_result  in  XLEN  final value of the MEM-stage instruction: load data for loads, otherwise exmem_result
op_a  out  XLEN  forwarded operand 1
op_b  out  XLEN  forwarded operand 2
exmem_result  out  XLEN  EX/MEM held result (memory address / store path)
exmem_valid  out  1  EX/MEM slot valid
memwb_result  out  XLEN  MEM/WB held result (write-back data)
memwb_valid  out  1  MEM/WB slot valid
fwd_err  out  1  sticky: a flag was asserted against an invalid slot
stall_count  out  CNT_W  saturating count of stall cycles
fwd_count  out  CNT_W  saturating count of cycles with any forward applied

Behaviour:
- Reset (async, rst=1): exmem_result/valid, memwb_result/valid, fwd_err, both counters = 0 immediately, regardless of clk. op_a/op_b then equal rs1_data/rs2_data.
- Operand muxes are combinational, zero latency, operand A:
  - forwarding_EX_EX1 && exmem_valid -> exmem_result
  - else forwarding_MEM_EX1 && memwb_valid -> memwb_result
  - else rs1_data
- Operand B: same priority using the *2 flags and rs2_data.
- EX-EX has priority over MEM-EX when both are set (newer producer wins).
- Rising edge, stall=0: exmem_result <= ex_result; exmem_valid <= ex_valid.
- Rising edge, stall=1: exmem_result <= 0; exmem_valid <= 0 (bubble). EX holds; upstream re-presents the same instruction next cycle.
- MEM/WB advances every non-reset edge, stall ignored: memwb_result <= mem_result; memwb_valid <= exmem_valid.
- fwd_err: set at an edge when any EX_EX flag is high while exmem_valid=0, or any MEM_EX flag is high while memwb_valid=0. Sticky until reset. The operand falls back to register-file data in that cycle.
- stall_count: +1 each edge with stall=1. Holds at 2^CNT_W-1 with no wrap.
- fwd_count: +1 each edge where either operand selected a forwarded source. Saturates at 2^CNT_W-1. Counts once per cycle even if both operands forward.
- Forwarding is still computed during a stall cycle but is not counted in fwd_count.
- Reset mid-operation: all state clears immediately; first post-reset edge behaves as from empty pipeline.
- No x-propagation: unknown flags are not defended against; the bench drives known values.

Test Plan:
- Reset: rst=1 then rs1_data=0x11, rs2_data=0x22, all flags high -> op_a=0x11, op_b=0x22, fwd_err=0, counters=0; after one edge fwd_err=1 (slots invalid).
- EX-EX: edge with ex_result=0x100, ex_valid=1, stall=0; then forwarding_EX_EX1=1 -> op_a=0x100, op_b=rs2_data; fwd_count increments to 1 on next edge.
- MEM-EX plus priority: load 0xA (cycle n), 0xB (cycle n+1) into EX/MEM, mem_result=0xA into MEM/WB; set both EX_EX2 and MEM_EX2 -> op_b=0xB; drop EX_EX2 -> op_b=mem_result captured (0xA).
- Load-use stall: stall=1 for one edge with ex_valid=1, ex_result=0x5 -> exmem_valid=0, exmem_result=0, stall_count=1; next edge memwb_valid=0.
- Saturation: CNT_W=4, stall held 20 cycles -> stall_count=15 and stays 15.
- Async reset mid-stream: assert rst between edges with all slots valid -> all outputs/state clear before next edge; fwd_err cleared.

Source files
------------

// File: rtl/ex_operand_forward.sv
// EX-stage operand forwarding: owns the EX/MEM and MEM/WB result slots, selects
// ALU operands from register file / EX-EX / MEM-EX, and keeps stall/forward counters.

module ex_fwd_mux #(
   parameter int XLEN = 32
) (
   input  logic            ee,
   input  logic            me,
   input  logic            ev,
   input  logic            wv,
   input  logic [XLEN-1:0] er,
   input  logic [XLEN-1:0] wr,
   input  logic [XLEN-1:0] rf,
   output logic [XLEN-1:0] op,
   output logic            used,
   output logic            bad
);
   // Newer producer (EX/MEM) wins; a flag against an empty slot falls back to rf.
   always_comb begin
      op   = rf;
      used = 1'b0;
      if (ee && ev) begin
         op   = er;
         used = 1'b1;
      end else if (me && wv) begin
         op   = wr;
         used = 1'b1;
      end
   end

   assign bad = (ee && !ev) || (me && !wv);
endmodule

module ex_operand_forward #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             forwarding_EX_EX1,
   input  logic             forwarding_EX_EX2,
   input  logic             forwarding_MEM_EX1,
   input  logic             forwarding_MEM_EX2,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   input  logic [XLEN-1:0]  ex_result,
   input  logic             ex_valid,
   input  logic [XLEN-1:0]  mem_result,
   output logic [XLEN-1:0]  op_a,
   output logic [XLEN-1:0]  op_b,
   output logic [XLEN-1:0]  exmem_result,
   output logic             exmem_valid,
   output logic [XLEN-1:0]  memwb_result,
   output logic             memwb_valid,
   output logic             fwd_err,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] fwd_count
);
   localparam int NUM_OPS = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_OPS-1:0]           ee, me, used, bad;
   logic [NUM_OPS-1:0][XLEN-1:0] rf, op;
   // vld_pipe[1] = EX/MEM slot, vld_pipe[2] = MEM/WB slot
   logic [2:1]                   vld_pipe;

   assign ee = {forwarding_EX_EX2, forwarding_EX_EX1};
   assign me = {forwarding_MEM_EX2, forwarding_MEM_EX1};
   assign rf = {rs2_data, rs1_data};

   generate
      for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
         ex_fwd_mux #(.XLEN(XLEN)) u_mux (
            .ee   (ee[g]),
            .me   (me[g]),
            .ev   (vld_pipe[1]),
            .wv   (vld_pipe[2]),
            .er   (exmem_result),
            .wr   (memwb_result),
            .rf   (rf[g]),
            .op   (op[g]),
            .used (used[g]),
            .bad  (bad[g])
         );
      end
   endgenerate

   assign op_a        = op[0];
   assign op_b        = op[1];
   assign exmem_valid = vld_pipe[1];
   assign memwb_valid = vld_pipe[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exmem_result <= '0;
         memwb_result <= '0;
         vld_pipe     <= '0;
         fwd_err      <= 1'b0;
         stall_count  <= '0;
         fwd_count    <= '0;
      end else begin
         // MEM/WB never stalls; a load-use stall only bubbles EX/MEM.
         memwb_result <= mem_result;
         vld_pipe[2]  <= vld_pipe[1];
         if (stall) begin
            exmem_result <= '0;
            vld_pipe[1]  <= 1'b0;
         end else begin
            exmem_result <= ex_result;
            vld_pipe[1]  <= ex_valid;
         end
         if (|bad)
            fwd_err <= 1'b1;
         if (stall && stall_count != CNT_MAX)
            stall_count <= stall_count + 1'b1;
         if (!stall && |used && fwd_count != CNT_MAX)
            fwd_count <= fwd_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_ex_operand_forward.sv
// Randomized and directed bench for ex_operand_forward against a behavioural model.

module tb_ex_operand_forward;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;
   logic stall, ee1, ee2, me1, me2, ex_valid;
   logic [XLEN-1:0] rs1_data, rs2_data, ex_result, mem_result;
   logic [XLEN-1:0] op_a, op_b, exmem_result, memwb_result;
   logic exmem_valid, memwb_valid, fwd_err;
   logic [CNT_W-1:0] stall_count, fwd_count;

   int total = 0;
   int bad   = 0;

   // behavioural model state
   logic [XLEN-1:0] m_exr, m_wbr;
   logic m_exv, m_wbv, m_err;
   int   m_sc, m_fc;

   always #5 clk = ~clk;

   ex_operand_forward #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .forwarding_EX_EX1(ee1), .forwarding_EX_EX2(ee2),
      .forwarding_MEM_EX1(me1), .forwarding_MEM_EX2(me2),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .ex_result(ex_result), .ex_valid(ex_valid), .mem_result(mem_result),
      .op_a(op_a), .op_b(op_b),
      .exmem_result(exmem_result), .exmem_valid(exmem_valid),
      .memwb_result(memwb_result), .memwb_valid(memwb_valid),
      .fwd_err(fwd_err), .stall_count(stall_count), .fwd_count(fwd_count)
   );

   function automatic logic [XLEN-1:0] pick(input logic ee, input logic me, input logic [XLEN-1:0] rf);
      if (ee && m_exv) return m_exr;
      if (me && m_wbv) return m_wbr;
      return rf;
   endfunction

   task automatic model_clear();
      m_exr = '0; m_wbr = '0; m_exv = 0; m_wbv = 0; m_err = 0; m_sc = 0; m_fc = 0;
   endtask

   task automatic idle_inputs();
      stall = 0; ee1 = 0; ee2 = 0; me1 = 0; me2 = 0; ex_valid = 0;
      rs1_data = '0; rs2_data = '0; ex_result = '0; mem_result = '0;
   endtask

   // One clock edge; the model advances with the inputs held across that edge.
   task automatic tick();
      logic fwd_any, err;
      fwd_any = (ee1 && m_exv) || (me1 && m_wbv) || (ee2 && m_exv) || (me2 && m_wbv);
      err = ((ee1 || ee2) && !m_exv) || ((me1 || me2) && !m_wbv);
      @(posedge clk);
      m_wbr = mem_result;
      m_wbv = m_exv;
      m_exr = stall ? '0 : ex_result;
      m_exv = stall ? 1'b0 : ex_valid;
      if (err) m_err = 1;
      if (stall && m_sc < CMAX) m_sc++;
      if (!stall && fwd_any && m_fc < CMAX) m_fc++;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      model_clear();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1; idle_inputs();
      rs1_data = 32'h11; rs2_data = 32'h22;
      ee1 = 1; ee2 = 1; me1 = 1; me2 = 1;
      model_clear();
      #1;
      total++; if (op_a !== 32'h11) begin bad++; $display("FAIL reset_op_a got=%h exp=%h", op_a, 32'h11); end
      total++; if (op_b !== 32'h22) begin bad++; $display("FAIL reset_op_b got=%h exp=%h", op_b, 32'h22); end
      total++; if (fwd_err !== 1'b0) begin bad++; $display("FAIL reset_fwd_err got=%b exp=0", fwd_err); end
      total++; if (stall_count !== '0 || fwd_count !== '0) begin bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_count, fwd_count); end
      total++; if (exmem_valid !== 1'b0 || memwb_valid !== 1'b0) begin bad++; $display("FAIL reset_valids got=%b%b exp=00", exmem_valid, memwb_valid); end
      @(negedge clk);
      rst = 0;
      tick();
      total++; if (fwd_err !== 1'b1) begin bad++; $display("FAIL reset_err_after_edge got=%b exp=1", fwd_err); end
      total++; if (fwd_count !== '0) begin bad++; $display("FAIL reset_fwd_count_invalid got=%0d exp=0", fwd_count); end
   endtask

   task automatic test_ex_ex();
      do_reset(); idle_inputs();
      ex_result = 32'h100; ex_valid = 1;
      tick();
      ex_valid = 0; ee1 = 1; rs1_data = 32'h55; rs2_data = 32'h77;
      #1;
      total++; if (op_a !== 32'h100) begin bad++; $display("FAIL exex_op_a got=%h exp=%h", op_a, 32'h100); end
      total++; if (op_b !== 32'h77) begin bad++; $display("FAIL exex_op_b got=%h exp=%h", op_b, 32'h77); end
      tick();
      total++; if (fwd_count !== 4'd1) begin bad++; $display("FAIL exex_fwd_count got=%0d exp=1", fwd_count); end
      total++; if (fwd_err !== 1'b0) begin bad++; $display("FAIL exex_no_err got=%b exp=0", fwd_err); end
   endtask

   task automatic test_mem_ex_priority();
      do_reset(); idle_inputs();
      ex_result = 32'hA; ex_valid = 1;
      tick();
      ex_result = 32'hB; mem_result = 32'hA;
      tick();
      ex_valid = 0; mem_result = 32'h0; rs2_data = 32'h99;
      ee2 = 1; me2 = 1;
      #1;
      total++; if (op_b !== 32'hB) begin bad++; $display("FAIL prio_op_b got=%h exp=%h", op_b, 32'hB); end
      ee2 = 0;
      #1;
      total++; if (op_b !== 32'hA) begin bad++; $display("FAIL memex_op_b got=%h exp=%h", op_b, 32'hA); end
      tick();
      total++; if (fwd_count !== 4'd1) begin bad++; $display("FAIL memex_fwd_count got=%0d exp=1", fwd_count); end
   endtask

   task automatic test_stall();
      do_reset(); idle_inputs();
      ex_result = 32'h3; ex_valid = 1;
      tick();
      stall = 1; ex_result = 32'h5; ee1 = 1;
      tick();
      total++; if (exmem_valid !== 1'b0 || exmem_result !== '0) begin bad++; $display("FAIL stall_bubble got=%b/%h exp=0/0", exmem_valid, exmem_result); end
      total++; if (stall_count !== 4'd1) begin bad++; $display("FAIL stall_count got=%0d exp=1", stall_count); end
      total++; if (fwd_count !== 4'd0) begin bad++; $display("FAIL stall_no_fwd_count got=%0d exp=0", fwd_count); end
      stall = 0; ee1 = 0;
      tick();
      total++; if (memwb_valid !== 1'b0) begin bad++; $display("FAIL stall_memwb_valid got=%b exp=0", memwb_valid); end
      total++; if (exmem_result !== 32'h5) begin bad++; $display("FAIL stall_replay got=%h exp=5", exmem_result); end
   endtask

   task automatic test_saturation();
      do_reset(); idle_inputs();
      stall = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         total++; if (stall_count !== CNT_W'(m_sc)) begin bad++; $display("FAIL sat_step%0d got=%0d exp=%0d", i, stall_count, m_sc); end
      end
      total++; if (stall_count !== 4'd15) begin bad++; $display("FAIL sat_final got=%0d exp=15", stall_count); end
      stall = 0;
   endtask

   task automatic test_async_reset();
      do_reset(); idle_inputs();
      me1 = 1;
      tick();
      me1 = 0; ex_valid = 1; ex_result = 32'h1234; mem_result = 32'h5678;
      tick();
      tick();
      rs1_data = 32'hCAFE; rs2_data = 32'hBEEF; ee1 = 1; me2 = 1;
      total++; if (fwd_err !== 1'b1 || exmem_valid !== 1'b1 || memwb_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b%b%b exp=111", fwd_err, exmem_valid, memwb_valid); end
      #2;
      rst = 1;
      model_clear();
      #1;
      total++; if (exmem_valid !== 1'b0 || memwb_valid !== 1'b0 || exmem_result !== '0 || memwb_result !== '0) begin bad++; $display("FAIL arst_slots got=%b%b %h %h exp=00 0 0", exmem_valid, memwb_valid, exmem_result, memwb_result); end
      total++; if (fwd_err !== 1'b0 || stall_count !== '0 || fwd_count !== '0) begin bad++; $display("FAIL arst_state got=%b %0d %0d exp=0 0 0", fwd_err, stall_count, fwd_count); end
      total++; if (op_a !== 32'hCAFE || op_b !== 32'hBEEF) begin bad++; $display("FAIL arst_ops got=%h %h exp=cafe beef", op_a, op_b); end
      @(negedge clk);
      rst = 0; ee1 = 0; me2 = 0;
   endtask

   task automatic test_random();
      do_reset(); idle_inputs();
      for (int i = 0; i < 300; i++) begin
         stall      = ($urandom_range(0, 4) == 0);
         ee1        = 1'($urandom_range(0, 1));
         ee2        = 1'($urandom_range(0, 1));
         me1        = 1'($urandom_range(0, 1));
         me2        = 1'($urandom_range(0, 1));
         ex_valid   = ($urandom_range(0, 3) != 0);
         rs1_data   = $urandom();
         rs2_data   = $urandom();
         ex_result  = $urandom();
         mem_result = $urandom();
         #1;
         total++; if (op_a !== pick(ee1, me1, rs1_data)) begin bad++; $display("FAIL rand_op_a[%0d] got=%h exp=%h", i, op_a, pick(ee1, me1, rs1_data)); end
         total++; if (op_b !== pick(ee2, me2, rs2_data)) begin bad++; $display("FAIL rand_op_b[%0d] got=%h exp=%h", i, op_b, pick(ee2, me2, rs2_data)); end
         tick();
         total++;
         if (exmem_result !== m_exr || exmem_valid !== m_exv || memwb_result !== m_wbr || memwb_valid !== m_wbv) begin
            bad++; $display("FAIL rand_slots[%0d] got=%h/%b %h/%b exp=%h/%b %h/%b", i,
               exmem_result, exmem_valid, memwb_result, memwb_valid, m_exr, m_exv, m_wbr, m_wbv);
         end
         total++;
         if (fwd_err !== m_err || stall_count !== CNT_W'(m_sc) || fwd_count !== CNT_W'(m_fc)) begin
            bad++; $display("FAIL rand_state[%0d] got=%b %0d %0d exp=%b %0d %0d", i,
               fwd_err, stall_count, fwd_count, m_err, m_sc, m_fc);
         end
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      model_clear();
      test_reset();
      test_ex_ex();
      test_mem_ex_priority();
      test_stall();
      test_saturation();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
